// File: rtl/inst_mem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_mem_loader : byte stream -> 16-bit instruction memory writer, hi first
// Rev 1.0
// ----------------------------------------------------------------------------
module inst_mem_loader #(
  parameter int ADDR_W = 5,
  parameter int WORDS  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(WORDS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_hi;
  logic [7:0]        r_checksum;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              w_accept;
  logic              w_start;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_next = S_HI;
      end
      S_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (abort)           w_next = S_IDLE;
        else if (byte_valid) w_next = S_LO;
      end
      S_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (abort)           w_next = S_IDLE;
        else if (byte_valid) w_next = S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1;
        if (abort)                w_next = S_IDLE;
        else if (r_addr == c_LAST) w_next = S_DONE;
        else                      w_next = S_HI;
      end
      S_DONE: begin
        done = 1'b1;
        // abort alongside start drops to IDLE; abort alone leaves done set
        if (start) w_next = abort ? S_IDLE : S_HI;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = byte_valid && byte_ready && !abort;
  assign w_start  = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_hi       <= '0;
      r_checksum <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_addr     <= '0;
        r_checksum <= '0;
      end
      if (w_accept) begin
        r_checksum <= r_checksum ^ byte_data;
        if (r_state == S_HI) begin
          r_hi <= byte_data;
        end else begin
          // the write strobe is launched here so it is high exactly in WRITE
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= {r_hi, byte_data};
        end
      end
      if ((r_state == S_WRITE) && !abort && (r_addr != c_LAST))
        r_addr <= r_addr + 1'b1;
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign checksum = r_checksum;

endmodule
`default_nettype wire
